// File: rtl/frac_div_monitor.sv
`default_nettype none
// ============================================================================
// frac_div_monitor : period/window checker for a fractional clock divider
// Revision 1.0
// ============================================================================
module frac_div_monitor #(
  parameter int DIV_E     = 8,
  parameter int DIV_O     = 9,
  parameter int WIN       = 10,
  parameter int EXP_SUM   = 87,
  parameter int STUCK_LIM = 32
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clk_div,
  input  logic        clr_err,
  output logic        per_valid,
  output logic [7:0]  per_len,
  output logic        win_valid,
  input  logic        win_ready,
  output logic [15:0] win_sum,
  output logic [7:0]  win_e_cnt,
  output logic [7:0]  win_o_cnt,
  output logic        win_ok,
  output logic        err_period,
  output logic        err_stuck,
  output logic        err_ovf
);

  localparam logic [7:0]  c_div_e    = 8'(DIV_E);
  localparam logic [7:0]  c_div_o    = 8'(DIV_O);
  localparam logic [7:0]  c_win_last = 8'(WIN - 1);
  localparam logic [15:0] c_exp_sum  = 16'(EXP_SUM);
  localparam logic [7:0]  c_stuck    = 8'(STUCK_LIM);

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, MEAS = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        s_q, s_d;
  logic [7:0]  pcnt_q, pcnt_d;
  logic [15:0] sum_q, sum_d;
  logic [7:0]  e_q, e_d, o_q, o_d, idx_q, idx_d;
  logic        bad_q, bad_d;
  logic        per_valid_q, per_valid_d;
  logic [7:0]  per_len_q, per_len_d;
  logic        win_valid_q, win_valid_d;
  logic [15:0] win_sum_q, win_sum_d;
  logic [7:0]  win_e_q, win_e_d, win_o_q, win_o_d;
  logic        win_ok_q, win_ok_d;
  logic        err_period_q, err_period_d;
  logic        err_stuck_q, err_stuck_d;
  logic        err_ovf_q, err_ovf_d;

  logic        rise, is_e, is_o, illegal, accept, win_done;
  logic        set_period, set_stuck, set_ovf;
  logic [15:0] acc_sum;
  logic [7:0]  acc_e, acc_o, pcnt_inc;
  logic        acc_bad;

  always_comb begin
    rise     = clk_div & ~s_q;
    is_e     = (pcnt_q == c_div_e);
    is_o     = (pcnt_q == c_div_o);
    illegal  = ~is_e & ~is_o;
    // Window totals including the period that ends on this rise
    acc_sum  = sum_q + {8'd0, pcnt_q};
    acc_e    = e_q + {7'd0, is_e};
    acc_o    = o_q + {7'd0, is_o};
    acc_bad  = bad_q | illegal;
    pcnt_inc = (pcnt_q == 8'hFF) ? pcnt_q : pcnt_q + 8'd1;
    accept   = win_valid_q & win_ready;

    s_d         = clk_div;
    state_d     = state_q;
    pcnt_d      = pcnt_q;
    sum_d       = sum_q;
    e_d         = e_q;
    o_d         = o_q;
    idx_d       = idx_q;
    bad_d       = bad_q;
    per_valid_d = 1'b0;
    per_len_d   = per_len_q;
    win_valid_d = win_valid_q;
    win_sum_d   = win_sum_q;
    win_e_d     = win_e_q;
    win_o_d     = win_o_q;
    win_ok_d    = win_ok_q;
    win_done    = 1'b0;
    set_period  = 1'b0;
    set_stuck   = 1'b0;
    set_ovf     = 1'b0;

    if (!en) begin
      state_d = IDLE;
      pcnt_d  = 8'd0;
      sum_d   = 16'd0;
      e_d     = 8'd0;
      o_d     = 8'd0;
      idx_d   = 8'd0;
      bad_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARM;
          pcnt_d  = 8'd0;
        end
        ARM: begin
          if (rise) begin
            state_d = MEAS;
            pcnt_d  = 8'd1;
            sum_d   = 16'd0;
            e_d     = 8'd0;
            o_d     = 8'd0;
            idx_d   = 8'd0;
            bad_d   = 1'b0;
          end else if (pcnt_q == c_stuck) begin
            set_stuck = 1'b1;
            pcnt_d    = 8'd0;
          end else begin
            pcnt_d = pcnt_inc;
          end
        end
        MEAS: begin
          if (rise) begin
            pcnt_d      = 8'd1;
            per_valid_d = 1'b1;
            per_len_d   = pcnt_q;
            set_period  = illegal;
            if (idx_q == c_win_last) begin
              // Current rise opens the next window, so no period is lost
              win_done = 1'b1;
              sum_d    = 16'd0;
              e_d      = 8'd0;
              o_d      = 8'd0;
              idx_d    = 8'd0;
              bad_d    = 1'b0;
            end else begin
              sum_d = acc_sum;
              e_d   = acc_e;
              o_d   = acc_o;
              bad_d = acc_bad;
              idx_d = idx_q + 8'd1;
            end
          end else if (pcnt_q == c_stuck) begin
            set_stuck = 1'b1;
            state_d   = ARM;
            pcnt_d    = 8'd0;
            sum_d     = 16'd0;
            e_d       = 8'd0;
            o_d       = 8'd0;
            idx_d     = 8'd0;
            bad_d     = 1'b0;
          end else begin
            pcnt_d = pcnt_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (win_done) begin
      if (!win_valid_q || accept) begin
        win_valid_d = 1'b1;
        win_sum_d   = acc_sum;
        win_e_d     = acc_e;
        win_o_d     = acc_o;
        win_ok_d    = (acc_sum == c_exp_sum) && !acc_bad;
      end else begin
        set_ovf = 1'b1;
      end
    end else if (accept) begin
      win_valid_d = 1'b0;
    end

    err_period_d = (err_period_q & ~clr_err) | set_period;
    err_stuck_d  = (err_stuck_q  & ~clr_err) | set_stuck;
    err_ovf_d    = (err_ovf_q    & ~clr_err) | set_ovf;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      s_q          <= 1'b0;
      pcnt_q       <= 8'd0;
      sum_q        <= 16'd0;
      e_q          <= 8'd0;
      o_q          <= 8'd0;
      idx_q        <= 8'd0;
      bad_q        <= 1'b0;
      per_valid_q  <= 1'b0;
      per_len_q    <= 8'd0;
      win_valid_q  <= 1'b0;
      win_sum_q    <= 16'd0;
      win_e_q      <= 8'd0;
      win_o_q      <= 8'd0;
      win_ok_q     <= 1'b0;
      err_period_q <= 1'b0;
      err_stuck_q  <= 1'b0;
      err_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      pcnt_q       <= pcnt_d;
      sum_q        <= sum_d;
      e_q          <= e_d;
      o_q          <= o_d;
      idx_q        <= idx_d;
      bad_q        <= bad_d;
      per_valid_q  <= per_valid_d;
      per_len_q    <= per_len_d;
      win_valid_q  <= win_valid_d;
      win_sum_q    <= win_sum_d;
      win_e_q      <= win_e_d;
      win_o_q      <= win_o_d;
      win_ok_q     <= win_ok_d;
      err_period_q <= err_period_d;
      err_stuck_q  <= err_stuck_d;
      err_ovf_q    <= err_ovf_d;
    end
  end

  assign per_valid  = per_valid_q;
  assign per_len    = per_len_q;
  assign win_valid  = win_valid_q;
  assign win_sum    = win_sum_q;
  assign win_e_cnt  = win_e_q;
  assign win_o_cnt  = win_o_q;
  assign win_ok     = win_ok_q;
  assign err_period = err_period_q;
  assign err_stuck  = err_stuck_q;
  assign err_ovf    = err_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_frac_div_monitor.sv
`default_nettype none
// ============================================================================
// tb_frac_div_monitor : directed bench for frac_div_monitor
// Revision 1.0
// ============================================================================
module tb_frac_div_monitor;

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0, en = 1'b0, clk_div = 1'b0, clr_err = 1'b0, win_ready = 1'b1;
  logic        per_valid, win_valid, win_ok, err_period, err_stuck, err_ovf;
  logic [7:0]  per_len, win_e_cnt, win_o_cnt;
  logic [15:0] win_sum;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_in = ~clk_in;

  frac_div_monitor dut (
    .clk_in(clk_in), .rst_n(rst_n), .en(en), .clk_div(clk_div), .clr_err(clr_err),
    .per_valid(per_valid), .per_len(per_len), .win_valid(win_valid), .win_ready(win_ready),
    .win_sum(win_sum), .win_e_cnt(win_e_cnt), .win_o_cnt(win_o_cnt), .win_ok(win_ok),
    .err_period(err_period), .err_stuck(err_stuck), .err_ovf(err_ovf)
  );

  typedef struct packed {
    logic [15:0] sum;
    logic [7:0]  e;
    logic [7:0]  o;
    logic        ok;
  } win_res_t;

  typedef struct {
    int sub_idx;
    int sub_len;
    int err_before;
    int clr;
    int exp_sum;
    int exp_e;
    int exp_o;
    int exp_ok;
  } win_vec_t;

  int       base [10] = '{9, 9, 8, 9, 9, 8, 9, 9, 8, 9};
  win_vec_t vec  [6];
  logic [7:0] per_q [$];
  win_res_t   win_q [$];
  int         exp_per [$];

  always @(negedge clk_in) begin
    if (per_valid) per_q.push_back(per_len);
    if (win_valid && win_ready) win_q.push_back({win_sum, win_e_cnt, win_o_cnt, win_ok});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic period(input int len, input bit clr);
    for (int i = 0; i < len; i++) begin
      clk_div = (i < 4);
      clr_err = clr && (i == 0);
      tick();
    end
    clr_err = 1'b0;
  endtask

  task automatic run_win(input int sub_idx, input int sub_len, input bit clr);
    for (int k = 0; k < 10; k++) begin
      int len;
      len = (k == sub_idx) ? sub_len : base[k];
      exp_per.push_back(len);
      period(len, clr && (k == 0));
    end
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  task automatic chk_win(input string name, input int idx, input int s, input int e,
                         input int o, input int ok);
    if (idx < win_q.size()) begin
      chk({name, "_sum"}, 64'(win_q[idx].sum), 64'(s));
      chk({name, "_e"},   64'(win_q[idx].e),   64'(e));
      chk({name, "_o"},   64'(win_q[idx].o),   64'(o));
      chk({name, "_ok"},  64'(win_q[idx].ok),  64'(ok));
    end else begin
      chk({name, "_present"}, 64'(win_q.size()), 64'(idx + 1));
    end
  endtask

  task automatic chk_per(input string name);
    chk({name, "_cnt"}, 64'(per_q.size()), 64'(exp_per.size()));
    for (int i = 0; i < per_q.size() && i < exp_per.size(); i++)
      chk({name, "_len"}, 64'(per_q[i]), 64'(exp_per[i]));
  endtask

  task automatic clear_logs();
    per_q.delete();
    win_q.delete();
    exp_per.delete();
  endtask

  initial begin
    //             sub_idx sub_len err_before clr sum e  o  ok
    vec[0] = '{-1,  0,  0, 0, 87, 3, 7, 1};
    vec[1] = '{ 5,  9,  0, 0, 88, 2, 8, 0};
    vec[2] = '{-1,  0,  0, 0, 87, 3, 7, 1};
    vec[3] = '{ 4, 10,  0, 0, 88, 3, 6, 0};
    vec[4] = '{-1,  0,  1, 1, 87, 3, 7, 1};
    vec[5] = '{-1,  0,  0, 0, 87, 3, 7, 1};

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("reset_outputs", 64'({per_valid, per_len, win_valid, win_sum, win_e_cnt, win_o_cnt,
                              win_ok, err_period, err_stuck, err_ovf}), 64'd0);

    // Ideal source, a sum-only defect and an illegal period, then clear
    clear_logs();
    en = 1'b1;
    tick();
    for (int r = 0; r < 6; r++) begin
      chk("err_period_before", 64'(err_period), 64'(vec[r].err_before));
      run_win(vec[r].sub_idx, vec[r].sub_len, vec[r].clr != 0);
    end
    period(8, 1'b0);
    en = 1'b0;
    repeat (2) tick();
    chk("t1_win_cnt", 64'(win_q.size()), 64'd6);
    for (int r = 0; r < 6; r++)
      chk_win("t1_win", r, vec[r].exp_sum, vec[r].exp_e, vec[r].exp_o, vec[r].exp_ok);
    chk_per("t1_per");
    chk("t1_err_period", 64'(err_period), 64'd0);
    chk("t1_err_stuck", 64'(err_stuck), 64'd0);
    chk("t1_err_ovf", 64'(err_ovf), 64'd0);

    // Stuck-low source mid-window
    clear_logs();
    en = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) period(9, 1'b0);
    exp_per.push_back(9);
    exp_per.push_back(9);
    exp_per.push_back(9);
    for (int i = 0; i < 44; i++) begin
      clk_div = (i < 4);
      tick();
      if (i == 30) chk("t3_stuck_early", 64'(err_stuck), 64'd0);
      if (i == 36) chk("t3_stuck_set", 64'(err_stuck), 64'd1);
    end
    run_win(-1, 0, 1'b0);
    period(8, 1'b0);
    en = 1'b0;
    repeat (2) tick();
    chk_per("t3_per");
    chk("t3_win_cnt", 64'(win_q.size()), 64'd1);
    chk_win("t3_win", 0, 87, 3, 7, 1);
    chk("t3_err_stuck_hold", 64'(err_stuck), 64'd1);
    pulse_clr();
    chk("t3_err_clr", 64'({err_period, err_stuck, err_ovf}), 64'd0);

    // Back-pressure across two window completions
    clear_logs();
    win_ready = 1'b0;
    en = 1'b1;
    tick();
    run_win(-1, 0, 1'b0);
    run_win(2, 9, 1'b0);
    period(8, 1'b0);
    en = 1'b0;
    tick();
    chk("t4_valid_held", 64'(win_valid), 64'd1);
    chk("t4_sum_held", 64'(win_sum), 64'd87);
    chk("t4_e_held", 64'(win_e_cnt), 64'd3);
    chk("t4_o_held", 64'(win_o_cnt), 64'd7);
    chk("t4_ok_held", 64'(win_ok), 64'd1);
    chk("t4_err_ovf", 64'(err_ovf), 64'd1);
    win_ready = 1'b1;
    tick();
    chk("t4_valid_drop", 64'(win_valid), 64'd0);
    chk("t4_acc_cnt", 64'(win_q.size()), 64'd1);
    chk_win("t4_acc", 0, 87, 3, 7, 1);
    pulse_clr();

    // Enable dropped mid-window
    clear_logs();
    en = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) period(base[k], 1'b0);
    for (int k = 0; k < 5; k++) exp_per.push_back(base[k]);
    en = 1'b0;
    repeat (3) tick();
    chk("t5_no_partial", 64'(win_q.size()), 64'd0);
    en = 1'b1;
    tick();
    run_win(-1, 0, 1'b0);
    period(8, 1'b0);
    en = 1'b0;
    repeat (2) tick();
    chk_per("t5_per");
    chk("t5_win_cnt", 64'(win_q.size()), 64'd1);
    chk_win("t5_win", 0, 87, 3, 7, 1);

    // Reset with a pending result
    clear_logs();
    win_ready = 1'b0;
    en = 1'b1;
    tick();
    run_win(-1, 0, 1'b0);
    for (int k = 0; k < 3; k++) period(8, 1'b0);
    chk("t6_pending", 64'(win_valid), 64'd1);
    en = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_reset_outputs", 64'({per_valid, per_len, win_valid, win_sum, win_e_cnt, win_o_cnt,
                                 win_ok, err_period, err_stuck, err_ovf}), 64'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
